uart_tx_serializer: RTL and testbench

- Byte-wide UART transmitter that sits directly downstream of the baud-rate frequency divider.
- Consumes the divider's square-wave output (one bit period per rising edge) and serialises one byte per frame onto txd.
- Byte source (e.g. a ROM address sequencer) hands bytes over with a valid/ready handshake.
- Frame format: 8N1 by default; STOP_BITS and the optional parity bit are configurable.

---
 rtl/uart_tx_serializer.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serialises DATA_BITS + STOP_BITS frames on baud_in ticks.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bits.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 txd_q, txd_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic                 bit_tick;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bit_tick = sync2_q & ~hist_q;
  assign accept   = tx_valid & ready_q;

  assign tx_ready = ready_q;
  assign txd      = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    ready_d = ready_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        // accept wins over a coincident tick
        if (accept) begin
          shift_d = tx_data;
          ready_d = 1'b0;
          state_d = S_ARM;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      S_ARM: begin
        if (bit_tick) begin
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sync1_q <= baud_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a mid-bit sampling receiver checks frames.
// Directed bytes with hand-computed data, parity and frame timing.
module tb_uart_tx_serializer;

  localparam int BIT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_in = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, txd, tx_busy, tx_done;

  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   baud_half = 4;
  int   done_cnt = 0;
  int   done_wide = 0;
  logic done_prev = 1'b0;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_in  (baud_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial forever begin
    repeat (baud_half) @(negedge clk);
    baud_in = ~baud_in;
  end

  always @(negedge clk) begin
    if (tx_done && done_prev) done_wide++;
    if (tx_done) done_cnt++;
    done_prev = tx_done;
  end

  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rx_frame(output logic [7:0] d, output logic p,
                          output logic s, output int ts);
    int n;
    n  = 0;
    d  = 8'h00;
    p  = 1'b0;
    s  = 1'b0;
    ts = -1;
    while (txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rx_timeout", 32'(n >= 2000), 0);
    if (n >= 2000) return;
    ts = cyc;
    repeat (BIT / 2) @(negedge clk);
    check("rx_start", 32'(txd), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      d[i] = txd;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BIT) @(negedge clk);
    p = txd;
`endif
    repeat (BIT) @(negedge clk);
    s = txd;
  endtask

  task automatic one_frame(input logic [7:0] b, input logic ep,
                           input string tag);
    logic [7:0] d;
    logic       p, s;
    int         ts, dc, n;
    dc = done_cnt;
    n  = 0;
    while (tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy_to"}, 32'(n >= 500), 0);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
    check({tag, "_busy"}, 32'(tx_busy), 1);
    check({tag, "_rdy_lo"}, 32'(tx_ready), 0);
    rx_frame(d, p, s, ts);
    check({tag, "_data"}, 32'(d), 32'(b));
    check({tag, "_stop"}, 32'(s), 1);
`ifdef UART_TX_PARITY_EN
    check({tag, "_par"}, 32'(p), 32'(ep));
`else
    if (p !== 1'b0 || ep === 1'bx) check({tag, "_par"}, 32'(p), 0);
`endif
    repeat (12) @(negedge clk);
    check({tag, "_done"}, done_cnt - dc, 1);
    check({tag, "_rdy"}, 32'(tx_ready), 1);
    check({tag, "_idle"}, 32'(tx_busy), 0);
  endtask

  initial begin
    logic [7:0] d1, d2;
    logic       p1, p2, s1, s2;
    int         t1, t2, n, dc;

    // reset with the divider running fast
    repeat (40) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_rdy", 32'(tx_ready), 1);
    check("rst_busy", 32'(tx_busy), 0);
    baud_half = BIT / 2;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rel_txd", 32'(txd), 1);
    check("rel_rdy", 32'(tx_ready), 1);
    check("rel_busy", 32'(tx_busy), 0);
    check("rel_done", done_cnt, 0);

    one_frame(8'hA5, 1'b0, "a5");
    one_frame(8'h07, 1'b1, "07");

    // back-to-back with tx_valid held across the first frame
    dc = done_cnt;
    fork
      begin
        rx_frame(d1, p1, s1, t1);
        rx_frame(d2, p2, s2, t2);
      end
      begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        tx_data = 8'h0F;
        n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        check("b2b_rdy_to", 32'(n >= 1000), 0);
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check("b2b_d1", 32'(d1), 32'h55);
    check("b2b_d2", 32'(d2), 32'h0F);
    check("b2b_s1", 32'(s1), 1);
    check("b2b_s2", 32'(s2), 1);
`ifdef UART_TX_PARITY_EN
    check("b2b_p1", 32'(p1), 0);
    check("b2b_p2", 32'(p2), 0);
`endif
    check("b2b_gap", t2 - t1, (FBITS + 1) * BIT);
    repeat (12) @(negedge clk);
    check("b2b_done", done_cnt - dc, 2);

    // source keeps pushing while a frame is in flight
    fork
      one_frame(8'hC3, 1'b0, "hold");
      begin
        repeat (30) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
          tx_valid = 1'b1;
          tx_data  = 8'($urandom);
          @(negedge clk);
        end
        check("hold_rdy", 32'(tx_ready), 0);
        tx_valid = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    check("hold_no_2nd", 32'(tx_busy), 0);

    // reset in the middle of data bit 3
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    dc = done_cnt;
    n  = 0;
    while (txd !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mr_start_to", 32'(n >= 500), 0);
    repeat (BIT / 2 + 4 * BIT) @(negedge clk);
    check("mr_d3", 32'(txd), 0);
    #2 rst = 1'b0;
    #1;
    check("mr_txd", 32'(txd), 1);
    check("mr_busy", 32'(tx_busy), 0);
    check("mr_rdy", 32'(tx_ready), 1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("mr_no_done", done_cnt - dc, 0);
    check("mr_idle_txd", 32'(txd), 1);
    one_frame(8'h3C, 1'b0, "post_rst");

    check("done_width", done_wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
